calc_sequencer: RTL and testbench
=================================

# calc_sequencer

Control and arithmetic sequencer for the four-function calculator. It accepts the keypad command stream, builds the operands, applies operators left to right, and runs the arithmetic. Add and subtract take one cycle; multiply uses an iterative shift-add. Its outputs are the value to display, the digit count and a status code. It sits between the keypad decoder and the display driver; binary-to-digit conversion for the display is done downstream.

## Interface
- WIDTH, 28: signed operand/result width in bits, two's complement.
- MAX_DIGITS, 8: maximum number of decimal digits in an entered operand.
- LIMIT, 99_999_999: largest legal result magnitude; must fit in WIDTH-1 bits.
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- cmd  in  4  command code:
  - 0000-1001: digit 0-9
  - 1010: add
  - 1011: subtract
  - 1100: multiply
  - 1101: clear
  - 1110: equals
  - 1111: delete (backspace)
- cmd_valid  in  1  cmd is valid this cycle.
- ready  out  1  high when a command can be accepted.
- status  out  2  00 ENTRY, 01 BUSY, 10 RESULT, 11 ERROR.
- value  out  WIDTH  signed value to display.
- neg  out  1  equals value[WIDTH-1].
- digit_count  out  4  number of digits entered for the current operand.

## Operation
- Internal registers:
  - acc: signed accumulator.
  - opnd: operand being entered, non-negative.
  - op_pend: pending operator, one of NONE/ADD/SUB/MUL.
  - count: digits entered.
- A command is accepted on a rising edge with cmd_valid=1 and ready=1. If ready=0, the command is silently dropped.
- ENTRY state:
  - Digit d with count<MAX_DIGITS: opnd=opnd*10+d, count+1. Exception: when opnd==0 and d==0, nothing changes. When count==MAX_DIGITS the digit is ignored.
  - Delete: opnd=opnd/10 (truncating), count-1. Ignored when count==0.
  - Operator, op_pend==NONE: acc=opnd; op_pend=new op; opnd=0, count=0; stay in ENTRY.
  - Operator, op_pend!=NONE: go to BUSY and compute acc=acc op_pend opnd. Then op_pend=new op, opnd=0, count=0, return to ENTRY.
  - Equals, op_pend!=NONE: BUSY, then RESULT with op_pend=NONE.
  - Equals, op_pend==NONE: acc=opnd, go to RESULT.
- RESULT state:
  - Digit d: acc=0, op_pend=NONE, opnd=d, count=1 (count=0 if d==0), go to ENTRY.
  - Operator: op_pend=op, opnd=0, count=0, go to ENTRY; acc is kept and chains.
  - Equals and delete are ignored.
- ERROR state: only clear or reset leaves it; every other command is ignored.
- Clear, from any non-BUSY state: acc=0, opnd=0, count=0, op_pend=NONE, go to ENTRY.
- Arithmetic:
  - Add and subtract are exact in WIDTH+1 bits.
  - Multiply takes the magnitudes, performs shift-add over WIDTH iterations into a 2*WIDTH product, then applies the XOR of the operand signs.
  - If |result|>LIMIT the next state is ERROR instead of ENTRY/RESULT, and acc=0.
- value output:
  - ENTRY: acc if count==0 and op_pend!=NONE, else opnd.
  - RESULT: acc.
  - ERROR: 0.
  - BUSY: holds its previous value.

## Timing
- Reset values: status=00, value=0, neg=0, ready=1, digit_count=0, acc=opnd=0, op_pend=NONE.
- All outputs are registered. Reset takes effect immediately, including in the middle of a multiply, and aborts the operation.
- Accepted digit, delete, clear, and the non-computing operator/equals cases take effect at the accepting edge N and are visible after N.
- Computing command accepted at edge N:
  - ready=0 and status=01 after N.
  - Add/sub: result and the new state appear at edge N+1.
  - Multiply: result and the new state appear at edge N+WIDTH. ready is low for exactly WIDTH cycles.
- ready is low only in BUSY. Overflow detection adds no latency.

## Test plan
- Reset; digits 1,2,3 → value=123, digit_count=3. Delete → value=12, digit_count=2. Digits 0,0 from reset → value=0, digit_count=0.
- 12, add, 30, equals → ready low for 1 cycle, then status=10, value=42. Then 2, add, 3, multiply, 4, equals → value=20 (left-to-right chaining).
- 5, subtract, 9, equals → value=-4 (two's complement), neg=1.
- 1234, multiply, 5678, equals → ready low exactly 28 cycles, then value=7006652, status=10. A cmd_valid pulse during BUSY is dropped.
- 99999999, add, 1, equals → status=11, value=0. Digit 7 → ignored. Clear → status=00, value=0.
- Nine digits 1..9 → value=12345678, digit_count=8. Start a multiply, then assert reset mid-BUSY → all outputs return to reset values immediately and ready=1.

Source files
------------

// File: rtl/calc_sequencer_if.sv
// Keypad-to-display link of the calculator: command stream in, display value and status out.
// cmd/cmd_valid are taken on a rising clock edge only while ready is high; otherwise dropped.
interface calc_sequencer_if #(
    parameter int WIDTH = 28
);
    logic [3:0]              cmd;
    logic                    cmd_valid;
    logic                    ready;
    logic [1:0]              status;
    logic signed [WIDTH-1:0] value;
    logic                    neg;
    logic [3:0]              digit_count;

    modport master (
        output cmd, cmd_valid,
        input  ready, status, value, neg, digit_count
    );

    modport slave (
        input  cmd, cmd_valid,
        output ready, status, value, neg, digit_count
    );
endinterface

// File: rtl/calc_sequencer.sv
// Four-function calculator sequencer: operand entry, left-to-right operator chaining,
// single-cycle add/subtract and a WIDTH-cycle shift-add multiply. status is the FSM state.
module calc_sequencer #(
    parameter int WIDTH      = 28,
    parameter int MAX_DIGITS = 8,
    parameter int LIMIT      = 99_999_999
) (
    input  logic       clock,
    input  logic       reset,
    calc_sequencer_if.slave bus
);

    localparam int ITER_W = $clog2(WIDTH);
    localparam logic [ITER_W-1:0]  LAST_ITER = ITER_W'(WIDTH - 1);
    localparam logic [3:0]         MAXD      = 4'(MAX_DIGITS);
    localparam logic [2*WIDTH-1:0] LIMIT_P   = (2*WIDTH)'(LIMIT);
    localparam logic [WIDTH:0]     LIMIT_S   = (WIDTH+1)'(LIMIT);

    localparam logic [3:0] CMD_CLR = 4'd13;
    localparam logic [3:0] CMD_EQ  = 4'd14;
    localparam logic [3:0] CMD_DEL = 4'd15;

    typedef enum logic [1:0] {
        ST_ENTRY  = 2'b00,
        ST_BUSY   = 2'b01,
        ST_RESULT = 2'b10,
        ST_ERROR  = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_ADD  = 2'd1,
        OP_SUB  = 2'd2,
        OP_MUL  = 2'd3
    } op_t;

    state_t                  state_q;
    op_t                     op_pend_q;
    op_t                     busy_op_q;
    op_t                     next_op_q;
    logic                    to_result_q;
    logic signed [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]        opnd_q;
    logic [3:0]              count_q;
    logic signed [WIDTH-1:0] value_q;
    logic                    ready_q;
    logic [2*WIDTH-1:0]      mcand_q;
    logic [WIDTH-1:0]        mplr_q;
    logic [2*WIDTH-1:0]      prod_q;
    logic                    prod_neg_q;
    logic [ITER_W-1:0]       iter_q;

    // Command decode
    logic accept;
    logic is_digit;
    logic is_op;
    op_t  cmd_op;

    assign accept   = bus.cmd_valid && ready_q;
    assign is_digit = (bus.cmd < 4'd10);
    assign is_op    = (bus.cmd >= 4'd10) && (bus.cmd <= 4'd12);
    // Operator codes 1010/1011/1100 map onto ADD/SUB/MUL by subtracting one modulo 4.
    assign cmd_op   = op_t'(bus.cmd[1:0] - 2'd1);

    // Operand editing
    logic [WIDTH-1:0] opnd_append;
    logic [WIDTH-1:0] opnd_div10;
    logic             digit_takes;

    assign opnd_append = opnd_q * WIDTH'(10) + WIDTH'(bus.cmd);
    assign opnd_div10  = opnd_q / WIDTH'(10);
    assign digit_takes = (count_q < MAXD) && !((opnd_q == '0) && (bus.cmd == 4'd0));

    // Arithmetic datapath
    logic [WIDTH-1:0]        acc_mag;
    logic signed [WIDTH:0]   acc_ext;
    logic signed [WIDTH:0]   opnd_ext;
    logic signed [WIDTH:0]   sum_d;
    logic [WIDTH:0]          sum_mag;
    logic [2*WIDTH-1:0]      prod_d;
    logic [WIDTH-1:0]        prod_lo;
    logic signed [WIDTH-1:0] result_d;
    logic                    ovf_d;
    logic                    busy_done;

    assign acc_mag   = acc_q[WIDTH-1] ? -acc_q : acc_q;
    assign acc_ext   = {acc_q[WIDTH-1], acc_q};
    assign opnd_ext  = {1'b0, opnd_q};
    assign sum_d     = (busy_op_q == OP_SUB) ? (acc_ext - opnd_ext) : (acc_ext + opnd_ext);
    assign sum_mag   = sum_d[WIDTH] ? -sum_d : sum_d;
    assign prod_d    = prod_q + (mplr_q[0] ? mcand_q : '0);
    assign prod_lo   = prod_d[WIDTH-1:0];
    assign busy_done = (busy_op_q != OP_MUL) || (iter_q == LAST_ITER);

    // The final multiply step is folded into the completion edge so the result lands at N+WIDTH.
    always_comb begin
        result_d = '0;
        ovf_d    = 1'b0;
        if (busy_op_q == OP_MUL) begin
            ovf_d    = (prod_d > LIMIT_P);
            result_d = prod_neg_q ? -prod_lo : prod_lo;
        end else begin
            ovf_d    = (sum_mag > LIMIT_S);
            result_d = sum_d[WIDTH-1:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_ENTRY;
            op_pend_q   <= OP_NONE;
            busy_op_q   <= OP_NONE;
            next_op_q   <= OP_NONE;
            to_result_q <= 1'b0;
            acc_q       <= '0;
            opnd_q      <= '0;
            count_q     <= '0;
            value_q     <= '0;
            ready_q     <= 1'b1;
            mcand_q     <= '0;
            mplr_q      <= '0;
            prod_q      <= '0;
            prod_neg_q  <= 1'b0;
            iter_q      <= '0;
        end else if (accept && (bus.cmd == CMD_CLR)) begin
            state_q   <= ST_ENTRY;
            op_pend_q <= OP_NONE;
            acc_q     <= '0;
            opnd_q    <= '0;
            count_q   <= '0;
            value_q   <= '0;
        end else begin
            case (state_q)
                ST_ENTRY: begin
                    if (accept) begin
                        if (is_digit) begin
                            if (digit_takes) begin
                                opnd_q  <= opnd_append;
                                count_q <= count_q + 4'd1;
                                value_q <= opnd_append;
                            end
                        end else if (bus.cmd == CMD_DEL) begin
                            if (count_q != 4'd0) begin
                                opnd_q  <= opnd_div10;
                                count_q <= count_q - 4'd1;
                                value_q <= ((count_q == 4'd1) && (op_pend_q != OP_NONE)) ? acc_q : opnd_div10;
                            end
                        end else if (op_pend_q == OP_NONE) begin
                            acc_q   <= opnd_q;
                            value_q <= opnd_q;
                            if (is_op) begin
                                op_pend_q <= cmd_op;
                                opnd_q    <= '0;
                                count_q   <= '0;
                            end else begin
                                state_q <= ST_RESULT;
                            end
                        end else begin
                            busy_op_q   <= op_pend_q;
                            next_op_q   <= is_op ? cmd_op : OP_NONE;
                            to_result_q <= !is_op;
                            mcand_q     <= {{WIDTH{1'b0}}, acc_mag};
                            mplr_q      <= opnd_q;
                            prod_q      <= '0;
                            prod_neg_q  <= acc_q[WIDTH-1];
                            iter_q      <= '0;
                            ready_q     <= 1'b0;
                            state_q     <= ST_BUSY;
                        end
                    end
                end

                ST_BUSY: begin
                    if (busy_done) begin
                        ready_q   <= 1'b1;
                        op_pend_q <= next_op_q;
                        if (!to_result_q) begin
                            opnd_q  <= '0;
                            count_q <= '0;
                        end
                        if (ovf_d) begin
                            acc_q   <= '0;
                            value_q <= '0;
                            state_q <= ST_ERROR;
                        end else begin
                            acc_q   <= result_d;
                            value_q <= result_d;
                            state_q <= to_result_q ? ST_RESULT : ST_ENTRY;
                        end
                    end else begin
                        prod_q  <= prod_d;
                        mcand_q <= mcand_q << 1;
                        mplr_q  <= mplr_q >> 1;
                        iter_q  <= iter_q + 1'b1;
                    end
                end

                ST_RESULT: begin
                    if (accept) begin
                        if (is_digit) begin
                            acc_q     <= '0;
                            op_pend_q <= OP_NONE;
                            opnd_q    <= WIDTH'(bus.cmd);
                            count_q   <= (bus.cmd != 4'd0) ? 4'd1 : 4'd0;
                            value_q   <= WIDTH'(bus.cmd);
                            state_q   <= ST_ENTRY;
                        end else if (is_op) begin
                            op_pend_q <= cmd_op;
                            opnd_q    <= '0;
                            count_q   <= '0;
                            value_q   <= acc_q;
                            state_q   <= ST_ENTRY;
                        end
                    end
                end

                default: begin
                    // ERROR: only clear (handled above) or reset leaves this state.
                end
            endcase
        end
    end

    assign bus.ready       = ready_q;
    assign bus.status      = state_q;
    assign bus.value       = value_q;
    assign bus.neg         = value_q[WIDTH-1];
    assign bus.digit_count = count_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: a driver pushes hand-computed responses, a monitor
// pops one whenever ready is high after an accepted command and compares it.
module tb_calc_sequencer;
  localparam int W  = 28;
  localparam int EW = 6 + 2 + W + 4 + 1;

  localparam logic [3:0] K_ADD = 4'd10;
  localparam logic [3:0] K_SUB = 4'd11;
  localparam logic [3:0] K_MUL = 4'd12;
  localparam logic [3:0] K_CLR = 4'd13;
  localparam logic [3:0] K_EQ  = 4'd14;
  localparam logic [3:0] K_DEL = 4'd15;

  localparam logic [1:0] S_E = 2'd0;
  localparam logic [1:0] S_R = 2'd2;
  localparam logic [1:0] S_X = 2'd3;

  logic clock = 1'b0;
  logic reset;

  calc_sequencer_if #(.WIDTH(W)) bus ();

  calc_sequencer #(.WIDTH(W), .MAX_DIGITS(8), .LIMIT(99_999_999)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // clock / reset
  always #5 clock = ~clock;

  // scoreboard state: {busy cycles, status, value, digit_count, neg}
  logic [EW-1:0] exp_q[$];
  int pending = 0;
  int errors  = 0;
  int checks  = 0;

  function automatic logic [EW-1:0] pack(input int busy, input logic [1:0] st, input int v, input int cnt);
    logic signed [W-1:0] vv;
    vv = W'(v);
    return {6'(busy), st, vv, 4'(cnt), (v < 0)};
  endfunction

  function automatic void check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got busy=%0d status=%0d value=%0d count=%0d neg=%0d, expected busy=%0d status=%0d value=%0d count=%0d neg=%0d",
               name, act[EW-1 -: 6], act[W+6 -: 2], $signed(act[W+4 -: W]), act[4:1], act[0],
               exp[EW-1 -: 6], exp[W+6 -: 2], $signed(exp[W+4 -: W]), exp[4:1], exp[0]);
    end
  endfunction

  // monitor
  initial begin
    int busy_cnt;
    int idx;
    logic [EW-1:0] act;
    busy_cnt = 0;
    idx = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        busy_cnt = 0;
      end else if (pending > 0) begin
        if (bus.ready) begin
          act = {6'(busy_cnt), bus.status, bus.value, bus.digit_count, bus.neg};
          check($sformatf("resp%0d", idx), act, exp_q.pop_front());
          idx++;
          pending--;
          busy_cnt = 0;
        end else begin
          busy_cnt++;
          if (busy_cnt > 100) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: ready low for %0d cycles, required at most %0d", busy_cnt, W);
            void'(exp_q.pop_front());
            idx++;
            pending--;
            busy_cnt = 0;
          end
        end
      end
    end
  end

  // driver tasks
  task automatic issue(input logic [3:0] c, input bit expect_resp, input logic [EW-1:0] e);
    int guard;
    guard = 0;
    @(negedge clock);
    while (!bus.ready && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    if (!bus.ready) begin
      checks++;
      errors++;
      $display("FAIL ready_wait: ready=0 after %0d cycles, required 1", guard);
      return;
    end
    bus.cmd = c;
    bus.cmd_valid = 1'b1;
    @(posedge clock);
    if (expect_resp) begin
      exp_q.push_back(e);
      pending++;
    end
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic send(input logic [3:0] c, input logic [1:0] st, input int v, input int cnt, input int busy);
    issue(c, 1'b1, pack(busy, st, v, cnt));
  endtask

  task automatic drop_cmd(input logic [3:0] c);
    @(negedge clock);
    checks++;
    if (bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL drop_ready: ready=%0b during BUSY, required 0", bus.ready);
    end
    bus.cmd = c;
    bus.cmd_valid = 1'b1;
    @(posedge clock);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic reset_check(input string name);
    logic [EW-1:0] act;
    reset = 1'b1;
    #1;
    exp_q.delete();
    pending = 0;
    act = {6'd0, bus.status, bus.value, bus.digit_count, bus.neg};
    check(name, act, pack(0, S_E, 0, 0));
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready: got %0b, required 1", name, bus.ready);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  // stimulus
  initial begin
    int v;
    int g;
    reset = 1'b1;
    bus.cmd = 4'd0;
    bus.cmd_valid = 1'b0;
    #3;
    reset_check("reset_init");

    // entry, delete, leading zeros
    send(4'd1, S_E, 1, 1, 0);
    send(4'd2, S_E, 12, 2, 0);
    send(4'd3, S_E, 123, 3, 0);
    send(K_DEL, S_E, 12, 2, 0);
    send(K_CLR, S_E, 0, 0, 0);
    send(4'd0, S_E, 0, 0, 0);
    send(4'd0, S_E, 0, 0, 0);
    send(K_DEL, S_E, 0, 0, 0);

    // 12 + 30 = 42
    send(4'd1, S_E, 1, 1, 0);
    send(4'd2, S_E, 12, 2, 0);
    send(K_ADD, S_E, 12, 0, 0);
    send(4'd3, S_E, 3, 1, 0);
    send(4'd0, S_E, 30, 2, 0);
    send(K_EQ, S_R, 42, 2, 1);

    // 2 + 3 * 4 = 20 left to right
    send(4'd2, S_E, 2, 1, 0);
    send(K_ADD, S_E, 2, 0, 0);
    send(4'd3, S_E, 3, 1, 0);
    send(K_MUL, S_E, 5, 0, 1);
    send(4'd4, S_E, 4, 1, 0);
    send(K_EQ, S_R, 20, 1, W);

    // 5 - 9 = -4, with a delete back to an empty operand
    send(K_CLR, S_E, 0, 0, 0);
    send(4'd5, S_E, 5, 1, 0);
    send(K_SUB, S_E, 5, 0, 0);
    send(4'd9, S_E, 9, 1, 0);
    send(K_DEL, S_E, 5, 0, 0);
    send(4'd9, S_E, 9, 1, 0);
    send(K_EQ, S_R, -4, 1, 1);
    send(K_EQ, S_R, -4, 1, 0);
    send(K_DEL, S_R, -4, 1, 0);
    send(K_ADD, S_E, -4, 0, 0);
    send(4'd6, S_E, 6, 1, 0);
    send(K_EQ, S_R, 2, 1, 1);

    // 1234 * 5678 = 7006652, with a dropped command during BUSY
    send(K_CLR, S_E, 0, 0, 0);
    send(4'd1, S_E, 1, 1, 0);
    send(4'd2, S_E, 12, 2, 0);
    send(4'd3, S_E, 123, 3, 0);
    send(4'd4, S_E, 1234, 4, 0);
    send(K_MUL, S_E, 1234, 0, 0);
    send(4'd5, S_E, 5, 1, 0);
    send(4'd6, S_E, 56, 2, 0);
    send(4'd7, S_E, 567, 3, 0);
    send(4'd8, S_E, 5678, 4, 0);
    send(K_EQ, S_R, 7006652, 4, W);
    drop_cmd(4'd7);

    // 99999999 + 1 overflows to ERROR
    send(K_CLR, S_E, 0, 0, 0);
    v = 0;
    for (int i = 1; i <= 8; i++) begin
      v = v * 10 + 9;
      send(4'd9, S_E, v, i, 0);
    end
    send(K_ADD, S_E, 99999999, 0, 0);
    send(4'd1, S_E, 1, 1, 0);
    send(K_EQ, S_X, 0, 1, 1);
    send(4'd7, S_X, 0, 1, 0);
    send(K_EQ, S_X, 0, 1, 0);
    send(K_CLR, S_E, 0, 0, 0);

    // digit limit, then reset in the middle of a multiply
    v = 0;
    for (int i = 1; i <= 8; i++) begin
      v = v * 10 + i;
      send(4'(i), S_E, v, i, 0);
    end
    send(4'd9, S_E, 12345678, 8, 0);
    send(K_MUL, S_E, 12345678, 0, 0);
    send(4'd2, S_E, 2, 1, 0);
    issue(K_EQ, 1'b0, '0);
    repeat (10) @(negedge clock);
    #2;
    reset_check("reset_mid_busy");
    send(4'd4, S_E, 4, 1, 0);
    send(K_EQ, S_R, 4, 1, 0);

    g = 0;
    while (pending > 0 && g < 200) begin
      @(negedge clock);
      g++;
    end
    if (pending > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d responses outstanding, required 0", pending);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
